// File: rtl/lfsr_rng_arbiter_if.sv
// Requester-side bus of the shared LFSR random-word arbiter.
//   req       : one level request bit per requester, held until its word is accepted
//   grant     : one-hot current owner (0 when no word is in flight)
//   rsp_valid : random word is on rsp_data / rsp_id
//   rsp_ready : consumer accepts the word
//   rsp_data  : W-bit random word, first captured bit in the MSB
//   rsp_id    : index of the requester the word belongs to
// Handshake: a word transfers on a rising edge where rsp_valid && rsp_ready.
// While rsp_valid is high, rsp_data and rsp_id do not change. rsp_valid
// never drops without a transfer.
// master = requester/consumer side, slave = arbiter side.
interface lfsr_rng_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 8
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0] req;
  logic [NREQ-1:0] grant;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [W-1:0]    rsp_data;
  logic [IDW-1:0]  rsp_id;

  modport master (output req, rsp_ready, input grant, rsp_valid, rsp_data, rsp_id);
  modport slave  (input req, rsp_ready, output grant, rsp_valid, rsp_data, rsp_id);
endinterface

// File: rtl/lfsr_rng_arbiter.sv
// Shares one serial-output LFSR between NREQ requesters. A round-robin
// arbiter picks an owner, optionally reloads the LFSR (after reset or a
// config write), advances it exactly W times while shifting the serial bit
// into a word, then offers the word on a valid/ready response.
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   bus (slave)            : req/grant/rsp_* requester bus
//   i_cfg_we/seed/taps     : config write; a zero seed is rejected
//   o_cfg_err              : one-cycle pulse on a rejected config write
//   o_lfsr_reinit/advance  : LFSR control strobes
//   o_lfsr_initial_state   : seed register, o_lfsr_taps : taps register
//   i_lfsr_out             : LFSR serial output (registered, one cycle after advance)
//   o_dbg_state            : current FSM state
module lfsr_rng_arbiter #(
  parameter int           N         = 5,
  parameter int           W         = 8,
  parameter int           NREQ      = 4,
  parameter logic [N-1:0] SEED_INIT = 5'b00001,
  parameter logic [N-1:0] TAPS_INIT = 5'b10100
) (
  input  logic                 clk,
  input  logic                 rst_n,
  lfsr_rng_arbiter_if.slave    bus,
  input  logic                 i_cfg_we,
  input  logic [N-1:0]         i_cfg_seed,
  input  logic [N-1:0]         i_cfg_taps,
  output logic                 o_cfg_err,
  output logic                 o_lfsr_reinit,
  output logic                 o_lfsr_advance,
  output logic [N-1:0]         o_lfsr_initial_state,
  output logic [N-1:0]         o_lfsr_taps,
  input  logic                 i_lfsr_out,
  output logic [2:0]           o_dbg_state
);
  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(W);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SEED = 3'd1,
    S_RUN  = 3'd2,
    S_CAP  = 3'd3,
    S_RSP  = 3'd4
  } state_t;

  state_t          r_state;
  logic [IDW-1:0]  r_rr_ptr;
  logic [IDW-1:0]  r_owner;
  logic [NREQ-1:0] r_grant;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_data;
  logic            r_rsp_valid;
  logic            r_reinit;
  logic            r_advance;
  logic            r_cfg_err;
  logic [N-1:0]    r_seed;
  logic [N-1:0]    r_taps;
  logic            r_seed_pend;

  logic            w_found;
  logic [IDW-1:0]  w_pick;
  logic [IDW-1:0]  w_idx;

  // First requester at or after r_rr_ptr, scanning with wrap-around.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_idx = IDW'((int'(r_rr_ptr) + i) % NREQ);
      if (!w_found && bus.req[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_owner     <= '0;
      r_grant     <= '0;
      r_cnt       <= '0;
      r_data      <= '0;
      r_rsp_valid <= 1'b0;
      r_reinit    <= 1'b0;
      r_advance   <= 1'b0;
      r_cfg_err   <= 1'b0;
      r_seed      <= SEED_INIT;
      r_taps      <= TAPS_INIT;
      r_seed_pend <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_owner <= w_pick;
            r_grant <= NREQ'(1) << w_pick;
            r_cnt   <= '0;
            if (r_seed_pend) begin
              r_state  <= S_SEED;
              r_reinit <= 1'b1;
            end else begin
              r_state   <= S_RUN;
              r_advance <= 1'b1;
            end
          end
        end
        S_SEED: begin
          r_reinit    <= 1'b0;
          r_advance   <= 1'b1;
          r_seed_pend <= 1'b0;
          r_state     <= S_RUN;
        end
        S_RUN: begin
          // lfsr_out lags advance by one cycle, so the bit from the cnt==0
          // advance first appears at cnt==1; the last one is taken in CAP.
          if (r_cnt != '0) r_data <= {r_data[W-2:0], i_lfsr_out};
          if (r_cnt == CW'(W-1)) begin
            r_advance <= 1'b0;
            r_state   <= S_CAP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_CAP: begin
          r_data      <= {r_data[W-2:0], i_lfsr_out};
          r_rsp_valid <= 1'b1;
          r_state     <= S_RSP;
        end
        S_RSP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_grant     <= '0;
            r_rr_ptr    <= (int'(r_owner) == NREQ - 1) ? '0 : r_owner + 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // Placed after the FSM so a write landing in the SEED cycle keeps
      // seed_pend set; the reload itself used the old seed.
      r_cfg_err <= i_cfg_we && (i_cfg_seed == '0);
      if (i_cfg_we && (i_cfg_seed != '0)) begin
        r_seed      <= i_cfg_seed;
        r_taps      <= i_cfg_taps;
        r_seed_pend <= 1'b1;
      end
    end
  end

  assign bus.grant            = r_grant;
  assign bus.rsp_valid        = r_rsp_valid;
  assign bus.rsp_data         = r_data;
  assign bus.rsp_id           = r_owner;
  assign o_cfg_err            = r_cfg_err;
  assign o_lfsr_reinit        = r_reinit;
  assign o_lfsr_advance       = r_advance;
  assign o_lfsr_initial_state = r_seed;
  assign o_lfsr_taps          = r_taps;
  assign o_dbg_state          = r_state;
endmodule

// File: tb/tb_lfsr_rng_arbiter.sv
module tb_lfsr_rng_arbiter;
  localparam int           N         = 5;
  localparam int           W         = 8;
  localparam int           NREQ      = 4;
  localparam logic [N-1:0] SEED_INIT = 5'b00001;
  localparam logic [N-1:0] TAPS_INIT = 5'b10100;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst_n;
  logic         cfg_we;
  logic [N-1:0] cfg_seed;
  logic [N-1:0] cfg_taps;
  logic         cfg_err;
  logic         lfsr_reinit;
  logic         lfsr_advance;
  logic [N-1:0] lfsr_initial_state;
  logic [N-1:0] lfsr_taps;
  logic         lfsr_out = 1'b0;
  logic [2:0]   dbg_state;

  always #5 clk = ~clk;

  lfsr_rng_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

  lfsr_rng_arbiter #(
    .N(N), .W(W), .NREQ(NREQ), .SEED_INIT(SEED_INIT), .TAPS_INIT(TAPS_INIT)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .bus                  (bus),
    .i_cfg_we             (cfg_we),
    .i_cfg_seed           (cfg_seed),
    .i_cfg_taps           (cfg_taps),
    .o_cfg_err            (cfg_err),
    .o_lfsr_reinit        (lfsr_reinit),
    .o_lfsr_advance       (lfsr_advance),
    .o_lfsr_initial_state (lfsr_initial_state),
    .o_lfsr_taps          (lfsr_taps),
    .i_lfsr_out           (lfsr_out),
    .o_dbg_state          (dbg_state)
  );

  // ---------------- LFSR stub and monitor ----------------
  // Stub: each advance pops the next planned bit; it becomes visible one
  // cycle later, like a registered LFSR output.
  bit           bit_q[$];
  logic [W-1:0] exp_q[$];
  int           adv_cnt;
  int           reinit_cnt;
  logic [N-1:0] rs_seed;
  logic [N-1:0] rs_taps;

  always @(posedge clk) begin
    if (lfsr_advance) begin
      if (bit_q.size() > 0) lfsr_out <= bit_q.pop_front();
      else                  lfsr_out <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (lfsr_advance) adv_cnt++;
    if (lfsr_reinit) begin
      reinit_cnt++;
      rs_seed = lfsr_initial_state;
      rs_taps = lfsr_taps;
    end
  end

  // ---------------- scoreboard / reference model ----------------
  int           n_tests = 0;
  int           n_fail  = 0;
  int           m_ptr;
  int           m_pend;
  logic [N-1:0] m_seed;
  logic [N-1:0] m_taps;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Round-robin: first requester at or after the pointer, wrapping.
  function automatic int rr_model(input logic [NREQ-1:0] mask);
    for (int i = 0; i < NREQ; i++)
      if (mask[(m_ptr + i) % NREQ]) return (m_ptr + i) % NREQ;
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr  = 0;
    m_pend = 1;
    m_seed = SEED_INIT;
    m_taps = TAPS_INIT;
  endtask

  task automatic check_reset_outputs();
    check("rst_grant",     32'(bus.grant), 0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    check("rst_rsp_data",  32'(bus.rsp_data), 0);
    check("rst_rsp_id",    32'(bus.rsp_id), 0);
    check("rst_cfg_err",   32'(cfg_err), 0);
    check("rst_reinit",    32'(lfsr_reinit), 0);
    check("rst_advance",   32'(lfsr_advance), 0);
    check("rst_seed",      32'(lfsr_initial_state), 32'(SEED_INIT));
    check("rst_taps",      32'(lfsr_taps), 32'(TAPS_INIT));
  endtask

  // ---------------- driver tasks ----------------
  // All tasks start and end at 1 time unit after a rising edge.
  task automatic release_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [N-1:0] s, input logic [N-1:0] t);
    cfg_we = 1'b1; cfg_seed = s; cfg_taps = t;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    check("cfg_err_pulse", 32'(cfg_err), 32'(s == '0));
    if (s != '0) begin
      m_seed = s; m_taps = t; m_pend = 1;
    end
    check("cfg_seed_reg", 32'(lfsr_initial_state), 32'(m_seed));
    check("cfg_taps_reg", 32'(lfsr_taps), 32'(m_taps));
    @(posedge clk); #1;
    check("cfg_err_clear", 32'(cfg_err), 0);
  endtask

  // One complete word: request, optional config write cfg_at edges in,
  // wait for the response, hold it 'delay' cycles, then accept it.
  task automatic run_word(input logic [NREQ-1:0] mask, input logic [W-1:0] word,
                          input int delay, input int exp_id, input int exp_rs,
                          input bit drop, input int cfg_at,
                          input logic [N-1:0] cs, input logic [N-1:0] ct);
    int           lat;
    logic [W-1:0] exp_d;
    adv_cnt    = 0;
    reinit_cnt = 0;
    bus.req    = mask;
    for (int b = W - 1; b >= 0; b--) bit_q.push_back(word[b]);
    exp_q.push_back(word);
    lat = 0;
    while (!bus.rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (cfg_we) begin
        cfg_we = 1'b0;
        check("cfg_mid_seed", 32'(lfsr_initial_state), 32'(cs));
        check("cfg_mid_taps", 32'(lfsr_taps), 32'(ct));
      end
      if (lat == cfg_at) begin
        cfg_we = 1'b1; cfg_seed = cs; cfg_taps = ct;
      end
    end
    cfg_we = 1'b0;
    check("rsp_valid_seen", 32'(bus.rsp_valid), 1);
    check("latency",  32'(lat), 32'(W + 2 + exp_rs));
    check("rsp_id",   32'(bus.rsp_id), 32'(exp_id));
    check("grant",    32'(bus.grant), 32'(1 << exp_id));
    check("advances", 32'(adv_cnt), 32'(W));
    check("reseeds",  32'(reinit_cnt), 32'(exp_rs));
    if (reinit_cnt > 0) begin
      check("reseed_value", 32'(rs_seed), 32'(m_seed));
      check("reseed_taps",  32'(rs_taps), 32'(m_taps));
    end
    for (int d = 0; d < delay; d++) begin
      @(posedge clk); #1;
      check("valid_held", 32'(bus.rsp_valid), 1);
      check("data_held",  32'(bus.rsp_data), 32'(word));
      check("id_held",    32'(bus.rsp_id), 32'(exp_id));
    end
    exp_d = exp_q.pop_front();
    check("rsp_data", 32'(bus.rsp_data), 32'(exp_d));
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    check("valid_after_hs", 32'(bus.rsp_valid), 0);
    check("grant_after_hs", 32'(bus.grant), 0);
    if (drop) bus.req = '0;
    m_ptr = (exp_id + 1) % NREQ;
    if (exp_rs != 0) m_pend = 0;
    if (cfg_at > 0 && cs != '0) begin
      m_seed = cs; m_taps = ct; m_pend = 1;
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [NREQ-1:0] req;
    logic [W-1:0]    word;
    int              delay;
    int              exp_id;
    int              exp_rs;
    int              cfg_at;
    logic [N-1:0]    cs;
    logic [N-1:0]    ct;
  } vec_t;

  vec_t tbl[12];

  initial begin
    // first word after reset reseeds; bits 1,0,1,1,0,0,1,0 -> 8'hB2
    tbl[0]  = '{4'b0001, 8'hB2, 3, 0, 1, -1, 5'h00, 5'h00};
    tbl[1]  = '{4'b0001, 8'h5A, 0, 0, 0, -1, 5'h00, 5'h00};
    tbl[2]  = '{4'b0110, 8'hC3, 1, 1, 0, -1, 5'h00, 5'h00};
    tbl[3]  = '{4'b0110, 8'h3C, 0, 2, 0, -1, 5'h00, 5'h00};
    tbl[4]  = '{4'b1001, 8'hE7, 2, 3, 0, -1, 5'h00, 5'h00};
    tbl[5]  = '{4'b1001, 8'h18, 0, 0, 0, -1, 5'h00, 5'h00};
    tbl[6]  = '{4'b1000, 8'h99, 0, 3, 0, -1, 5'h00, 5'h00};
    // config written during RUN (cnt 4): word unaffected, next grant reseeds
    tbl[7]  = '{4'b0011, 8'hA5, 1, 0, 0,  5, 5'h13, 5'h12};
    tbl[8]  = '{4'b0101, 8'h6B, 0, 2, 1, -1, 5'h00, 5'h00};
    tbl[9]  = '{4'b0010, 8'hF0, 0, 1, 0,  3, 5'h0A, 5'h14};
    // config written in the SEED cycle: reload uses 0A, next word reseeds with 07
    tbl[10] = '{4'b0100, 8'h0F, 0, 2, 1,  1, 5'h07, 5'h1E};
    tbl[11] = '{4'b1000, 8'h81, 0, 3, 1, -1, 5'h00, 5'h00};
  end

  // ---------------- main test ----------------
  initial begin
    logic [NREQ-1:0] mask;
    logic [N-1:0]    s;
    int              id;

    rst_n = 1'b1;
    bus.req = '0; bus.rsp_ready = 1'b0;
    cfg_we = 1'b0; cfg_seed = '0; cfg_taps = '0;
    adv_cnt = 0; reinit_cnt = 0;
    rs_seed = '0; rs_taps = '0;
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    release_reset();

    for (int i = 0; i < 12; i++)
      run_word(tbl[i].req, tbl[i].word, tbl[i].delay, tbl[i].exp_id,
               tbl[i].exp_rs, 1'b1, tbl[i].cfg_at, tbl[i].cs, tbl[i].ct);

    // zero seed is rejected: error pulse, registers unchanged, no reseed
    cfg_write(5'h00, 5'h1F);
    check("rej_seed_kept", 32'(lfsr_initial_state), 32'h07);
    check("rej_taps_kept", 32'(lfsr_taps), 32'h1E);
    run_word(4'b0001, 8'h77, 1, 0, 0, 1'b1, -1, '0, '0);

    // all requesting, held: strict rotation 0,1,2,3,0 after a fresh reset
    rst_n = 1'b0;
    model_reset();
    release_reset();
    run_word(4'b1111, 8'h12, 0, 0, 1, 1'b0, -1, '0, '0);
    run_word(4'b1111, 8'h34, 0, 1, 0, 1'b0, -1, '0, '0);
    run_word(4'b1111, 8'h56, 0, 2, 0, 1'b0, -1, '0, '0);
    run_word(4'b1111, 8'h78, 0, 3, 0, 1'b0, -1, '0, '0);
    run_word(4'b1111, 8'h9A, 0, 0, 0, 1'b1, -1, '0, '0);

    // reset in the middle of a word (RUN, cnt 4)
    bus.req = 4'b0010;
    for (int b = W - 1; b >= 0; b--) bit_q.push_back(1'b1);
    repeat (5) @(posedge clk);
    #1;
    check("midword_grant",   32'(bus.grant), 32'b0010);
    check("midword_advance", 32'(lfsr_advance), 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    bus.req = '0;
    bit_q.delete();
    exp_q.delete();
    model_reset();
    release_reset();
    run_word(4'b0100, 8'h4E, 2, 2, 1, 1'b1, -1, '0, '0);

    // randomized words and config writes against the model
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        s = ($urandom_range(0, 3) == 0) ? 5'h00 : N'($urandom_range(1, 31));
        cfg_write(s, N'($urandom_range(0, 31)));
      end
      mask = NREQ'($urandom_range(1, 15));
      id   = rr_model(mask);
      run_word(mask, W'($urandom), $urandom_range(0, 3), id, m_pend, 1'b1, -1, '0, '0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
